uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: 8N1 (parameterisable data width), LSB first, idle-high line, mid-bit sampling from a clocks-per-bit timer. It is the receive-side counterpart to the UART transmitter and shares the same bit-timing scheme. It sits between the external RX pin and the byte-stream consumer, presenting each received byte on a valid/ready handshake with framing-error and overrun indications.

## Interface
- CLKS_PER_BIT, 25, i_clk cycles per serial bit; must be ≥ 4 (elaboration-time assertion)
- DATA_BITS, 8, data bits per frame (5..9)
- HALF, CLKS_PER_BIT/2 (integer division), derived, not overridable; offset of the start-bit sample
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high, on i_clk
- i_rx  in  1  serial line, asynchronous to i_clk, idle high
- o_data  out  DATA_BITS  received byte; stable while o_valid is high
- o_valid  out  1  byte available
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: byte completed while the previous one was still unaccepted
- o_busy  out  1  high in any state other than IDLE

## Operation
- i_rx passes through a 2-FF synchroniser whose stages reset to 1; rx_s is the second stage. All decisions use rx_s.
- FSM states are IDLE, START, DATA, STOP and WAIT_IDLE. Reset state is IDLE.
- IDLE: rx_s == 0 → START, bit timer cleared.
- START: sample rx_s HALF cycles after entry. If 1, the start was a glitch: → IDLE with no output. If 0 → DATA.
- DATA: sample every CLKS_PER_BIT cycles. Shift into the shift register MSB-side so the first bit lands in bit 0. After DATA_BITS samples → STOP.
- STOP: sample CLKS_PER_BIT cycles after the last data sample.
  - 1 → deliver the byte, → IDLE.
  - 0 → pulse o_frame_err, discard the byte, → WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then → IDLE. A break condition yields exactly one o_frame_err.
- Delivery:
  - If o_valid == 0, or o_valid && i_ready in the same cycle: load o_data and set o_valid. No overrun.
  - Otherwise keep the old o_data and o_valid, drop the new byte, and pulse o_overrun.
- o_valid clears on the cycle after the handshake, unless a delivery occurs in that same cycle.
- i_rst mid-frame: FSM → IDLE, shift register and timer cleared, pending o_valid dropped. No pulses are generated.
- Reset values: o_data = 0, o_valid = 0, o_frame_err = 0, o_overrun = 0, o_busy = 0.

## Timing
- rx_s lags i_rx by 2 cycles.
- Let t0 be the first cycle with rx_s == 0 in IDLE. All sample points below are normative:
  - Start sample: t0 + HALF.
  - Data bit k (k = 0..DATA_BITS-1): t0 + HALF + (k+1)·CLKS_PER_BIT.
  - Stop sample: t0 + HALF + (DATA_BITS+1)·CLKS_PER_BIT.
- o_valid, o_frame_err and o_overrun assert in the cycle after the stop sample.
  - With defaults: stop sample at t0 + 237, outputs at t0 + 238.
- Return to IDLE is immediate after a good stop sample. A start edge arriving 1 cycle later is accepted, giving back-to-back frames with no lost bit time.
- o_busy rises at t0 + 1 and falls in the cycle the FSM re-enters IDLE.
- Flags are registered. There are no combinational paths from i_rx or i_ready to any output.

## Structure
- uart_pkg holds:
  - the typedef rx_state_t (enum IDLE, START, DATA, STOP, WAIT_IDLE), shared with the TX FSM's package entries;
  - the default constants UART_CLKS_PER_BIT = 25 and UART_DATA_BITS = 8.
- The bit timer instantiates the existing uart_counter with N = CLKS_PER_BIT.
  - Its reset is i_rst OR the FSM restart strobe.
  - The HALF offset of the start bit is handled in the FSM, either by a preload or by a separate compare.
- The synchroniser is inline, not a sub-module.

## Test plan
- 0xA5 framed 8N1 at the default rate, i_ready = 1 → o_data = 0xA5 with o_valid for 1 cycle at t0 + 238. No error pulses.
- Low glitch on i_rx for 5 cycles (< HALF) → no o_valid, o_busy pulse only, FSM back in IDLE. Then 0x3C → received correctly.
- 0x81 with the stop bit held low for 3 bit times → one o_frame_err, no o_valid, o_busy held until the line returns high. Then 0x55 → received correctly.
- 0x11 then 0x22 back-to-back with i_ready = 0 → o_data stays 0x11 and o_overrun pulses once. Raising i_ready accepts 0x11. Then, with i_ready high on the cycle 0x33 completes, 0x33 loads with no overrun.
- i_rst asserted mid-DATA of 0xF0, released, then 0x0F sent → only 0x0F is delivered, and all outputs are 0 during reset.
- CLKS_PER_BIT = 4 and DATA_BITS = 5, sweeping 0..31 → all values received, with sample cycles matching the formulas above.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state type and default bit timing.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 25;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: valid/ready data plus status flags.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    output o_data, o_valid, o_frame_err, o_overrun, o_busy,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_overrun, o_busy,
    output i_ready
  );

endinterface

// File: rtl/uart_counter.sv
// Free-running modulo-N cycle counter used for UART bit timing.
module uart_counter #(
  parameter int N = 25
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic [$clog2(N)-1:0] o_count
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (o_count == LAST) begin
      o_count <= '0;
    end else begin
      o_count <= o_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling FSM, valid/ready output
// with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_rx,
  uart_rx_if.master rx_bus
);

  localparam int            HALF      = CLKS_PER_BIT / 2;
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx: DATA_BITS must be in 5..9");
  end

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [3:0]           bit_cnt;
  logic [CW-1:0]        timer;
  logic                 timer_rst;
  logic                 sample;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Timer is held at zero in IDLE, so it runs continuously from the cycle
  // after the start edge; every sample point falls where it reads HALF-1.
  assign timer_rst = i_rst | (state == IDLE);
  assign sample    = (timer == SAMPLE_AT);

  uart_counter #(
    .N(CLKS_PER_BIT)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (timer_rst),
    .o_count(timer)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      shift_reg          <= '0;
      bit_cnt            <= '0;
      rx_bus.o_data      <= '0;
      rx_bus.o_valid     <= 1'b0;
      rx_bus.o_frame_err <= 1'b0;
      rx_bus.o_overrun   <= 1'b0;
      rx_bus.o_busy      <= 1'b0;
    end else begin
      rx_bus.o_frame_err <= 1'b0;
      rx_bus.o_overrun   <= 1'b0;
      if (rx_bus.o_valid && rx_bus.i_ready) begin
        rx_bus.o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state         <= START;
            rx_bus.o_busy <= 1'b1;
          end
        end

        START: begin
          if (sample) begin
            if (rx_s) begin
              state         <= IDLE;
              rx_bus.o_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (sample) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        STOP: begin
          if (sample) begin
            if (rx_s) begin
              // A same-cycle handshake frees the output register for the new byte.
              if (!rx_bus.o_valid || rx_bus.i_ready) begin
                rx_bus.o_data  <= shift_reg;
                rx_bus.o_valid <= 1'b1;
              end else begin
                rx_bus.o_overrun <= 1'b1;
              end
              state         <= IDLE;
              rx_bus.o_busy <= 1'b0;
            end else begin
              rx_bus.o_frame_err <= 1'b1;
              state              <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state         <= IDLE;
            rx_bus.o_busy <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          rx_bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: two instances (25/8 and 4/5) compared every
// cycle against a sample-time model, plus directed literal checks.
module tb_uart_rx;

  localparam int CPB_A = 25;
  localparam int DB_A  = 8;
  localparam int CPB_B = 4;
  localparam int DB_B  = 5;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic rx_a    = 1'b1;
  logic rx_b    = 1'b1;
  logic ready_a = 1'b1;
  logic ready_b = 1'b1;

  uart_rx_if #(.DATA_BITS(DB_A)) bus_a ();
  uart_rx_if #(.DATA_BITS(DB_B)) bus_b ();

  assign bus_a.i_ready = ready_a;
  assign bus_b.i_ready = ready_b;

  uart_rx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .i_rx  (rx_a),
    .rx_bus(bus_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .i_rx  (rx_b),
    .rx_bus(bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   mode;
    int   t0;
    int   bits;
    logic s1;
    logic s2;
    int   data;
    logic valid;
    logic ferr;
    logic ovr;
    logic busy;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int   rise_a, data_rise_a, rises_a, ferr_cnt_a, ovr_cnt_a, busy_cnt_a;
  int   first_rise_b = -1;
  int   q_b[$];
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;
  bit   rand_on = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Mode 0 idle, 1 inside a frame, 2 waiting for the line to go high.
  // Sample instants are taken directly from t0 + HALF + n*CLKS_PER_BIT.
  task automatic model_step(inout mdl_t m, input int cpb, input int nb, input logic rx,
                            input logic rdy, input logic rst_in, input int c);
    int   half;
    int   rel;
    logic rxs;
    logic was_valid;
    half = cpb / 2;
    if (rst_in) begin
      m.mode = 0; m.s1 = 1'b1; m.s2 = 1'b1; m.data = 0; m.bits = 0;
      m.valid = 1'b0; m.ferr = 1'b0; m.ovr = 1'b0; m.busy = 1'b0;
      return;
    end
    rxs       = m.s2;
    was_valid = m.valid;
    m.ferr    = 1'b0;
    m.ovr     = 1'b0;
    if (m.valid && rdy) m.valid = 1'b0;
    case (m.mode)
      0: if (!rxs) begin m.mode = 1; m.t0 = c; m.bits = 0; end
      1: begin
        rel = c - m.t0 - half;
        if (rel == 0) begin
          if (rxs) m.mode = 0;
        end else if (rel > 0 && rel % cpb == 0) begin
          if (rel / cpb <= nb) begin
            m.bits |= int'(rxs) << (rel / cpb - 1);
          end else if (rxs) begin
            if (!was_valid || rdy) begin
              m.data  = m.bits;
              m.valid = 1'b1;
            end else begin
              m.ovr = 1'b1;
            end
            m.mode = 0;
          end else begin
            m.ferr = 1'b1;
            m.mode = 2;
          end
        end
      end
      default: if (rxs) m.mode = 0;
    endcase
    m.busy = (m.mode != 0);
    m.s2   = m.s1;
    m.s1   = rx;
  endtask

  always @(posedge clk) begin
    model_step(ma, CPB_A, DB_A, rx_a, ready_a, rst, cyc);
    model_step(mb, CPB_B, DB_B, rx_b, ready_b, rst, cyc);
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      checkOutput("a_outputs",
        32'({bus_a.o_busy, bus_a.o_overrun, bus_a.o_frame_err, bus_a.o_valid, 1'b0, bus_a.o_data}),
        32'({ma.busy, ma.ovr, ma.ferr, ma.valid, 1'b0, ma.data[7:0]}));
      checkOutput("b_outputs",
        32'({bus_b.o_busy, bus_b.o_overrun, bus_b.o_frame_err, bus_b.o_valid, 4'b0, bus_b.o_data}),
        32'({mb.busy, mb.ovr, mb.ferr, mb.valid, 4'b0, mb.data[4:0]}));
      if (bus_a.o_valid === 1'b1 && pv_a !== 1'b1) begin
        rise_a      = cyc;
        data_rise_a = int'(bus_a.o_data);
        rises_a++;
      end
      pv_a = bus_a.o_valid;
      if (bus_a.o_frame_err === 1'b1) ferr_cnt_a++;
      if (bus_a.o_overrun === 1'b1) ovr_cnt_a++;
      if (bus_a.o_busy === 1'b1) busy_cnt_a++;
      if (bus_b.o_valid === 1'b1 && pv_b !== 1'b1) begin
        if (q_b.size() == 0) first_rise_b = cyc;
        q_b.push_back(int'(bus_b.o_data));
      end
      pv_b = bus_b.o_valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic applyStimulus(input int which, input int value, input bit stop_ok, input int stop_bits);
    int c;
    int d;
    c = (which == 0) ? CPB_A : CPB_B;
    d = (which == 0) ? DB_A : DB_B;
    set_line(which, 1'b0);
    wait_cycles(c);
    for (int k = 0; k < d; k++) begin
      set_line(which, 1'((value >> k) & 1));
      wait_cycles(c);
    end
    set_line(which, stop_ok);
    wait_cycles(c * stop_bits);
    if (!stop_ok) begin
      set_line(which, 1'b1);
      wait_cycles(c);
    end
  endtask

  initial begin
    int k, r0, f0, o0, b0;
    wait_cycles(3);
    checkOutput("reset_a_all_zero",
      32'({bus_a.o_busy, bus_a.o_overrun, bus_a.o_frame_err, bus_a.o_valid, bus_a.o_data}), 32'd0);
    rst = 1'b0;
    wait_cycles(10);

    // 0xA5 at the default rate: valid lands 240 cycles after the start bit hits the pin.
    k = cyc;
    applyStimulus(0, 'hA5, 1'b1, 1);
    wait_cycles(10);
    checkOutput("a5_latency", 32'(rise_a - k), 32'd240);
    checkOutput("a5_data", 32'(data_rise_a), 32'hA5);
    checkOutput("a5_no_ferr", 32'(ferr_cnt_a), 32'd0);
    checkOutput("a5_no_ovr", 32'(ovr_cnt_a), 32'd0);

    // Short low glitch: busy for exactly HALF cycles, nothing delivered.
    b0 = busy_cnt_a; r0 = rises_a;
    rx_a = 1'b0; wait_cycles(5); rx_a = 1'b1; wait_cycles(30);
    checkOutput("glitch_busy_len", 32'(busy_cnt_a - b0), 32'd12);
    checkOutput("glitch_no_valid", 32'(rises_a - r0), 32'd0);
    applyStimulus(0, 'h3C, 1'b1, 1);
    wait_cycles(10);
    checkOutput("after_glitch_data", 32'(data_rise_a), 32'h3C);

    // Break-like stop bit: one framing error, no delivery.
    f0 = ferr_cnt_a; r0 = rises_a;
    applyStimulus(0, 'h81, 1'b0, 3);
    wait_cycles(10);
    checkOutput("break_ferr_once", 32'(ferr_cnt_a - f0), 32'd1);
    checkOutput("break_no_valid", 32'(rises_a - r0), 32'd0);
    applyStimulus(0, 'h55, 1'b1, 1);
    wait_cycles(10);
    checkOutput("after_break_data", 32'(data_rise_a), 32'h55);

    // Overrun, then a delivery coinciding with the handshake of the stale byte.
    ready_a = 1'b0;
    o0 = ovr_cnt_a;
    applyStimulus(0, 'h11, 1'b1, 1);
    applyStimulus(0, 'h22, 1'b1, 1);
    wait_cycles(5);
    checkOutput("ovr_held_data", 32'(bus_a.o_data), 32'h11);
    checkOutput("ovr_held_valid", 32'(bus_a.o_valid), 32'd1);
    checkOutput("ovr_pulse_once", 32'(ovr_cnt_a - o0), 32'd1);
    fork
      applyStimulus(0, 'h33, 1'b1, 1);
      begin
        wait_cycles(239);
        ready_a = 1'b1;
        wait_cycles(1);
        ready_a = 1'b0;
        checkOutput("swap_data", 32'(bus_a.o_data), 32'h33);
        checkOutput("swap_valid", 32'(bus_a.o_valid), 32'd1);
      end
    join
    wait_cycles(3);
    checkOutput("swap_no_ovr", 32'(ovr_cnt_a - o0), 32'd1);
    ready_a = 1'b1;
    wait_cycles(3);
    checkOutput("swap_accepted", 32'(bus_a.o_valid), 32'd0);

    // Reset in the middle of 0xF0 (start + low data bits), then 0x0F.
    r0 = rises_a;
    rx_a = 1'b0;
    wait_cycles(110);
    checkOutput("midframe_busy", 32'(bus_a.o_busy), 32'd1);
    rst = 1'b1; rx_a = 1'b1;
    wait_cycles(1);
    checkOutput("in_reset_a_zero",
      32'({bus_a.o_busy, bus_a.o_overrun, bus_a.o_frame_err, bus_a.o_valid, bus_a.o_data}), 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(5);
    applyStimulus(0, 'h0F, 1'b1, 1);
    wait_cycles(10);
    checkOutput("post_reset_count", 32'(rises_a - r0), 32'd1);
    checkOutput("post_reset_data", 32'(data_rise_a), 32'h0F);

    // Random traffic with random back-pressure, glitches and bad stop bits.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int sel;
          sel = $urandom_range(0, 9);
          if (sel == 0) begin
            rx_a = 1'b0; wait_cycles($urandom_range(1, 11)); rx_a = 1'b1; wait_cycles(20);
          end else if (sel == 1) begin
            applyStimulus(0, $urandom_range(0, 255), 1'b0, $urandom_range(1, 2));
          end else begin
            applyStimulus(0, $urandom_range(0, 255), 1'b1, 1);
          end
          wait_cycles($urandom_range(0, 15));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          ready_a = ($urandom_range(0, 3) != 0);
          wait_cycles(1);
        end
      end
    join
    ready_a = 1'b1;
    wait_cycles(10);

    // Narrow instance: sweep every 5-bit value back-to-back.
    k = cyc;
    for (int v = 0; v < 32; v++) applyStimulus(1, v, 1'b1, 1);
    wait_cycles(10);
    checkOutput("sweep_latency", 32'(first_rise_b - k), 32'd29);
    checkOutput("sweep_count", 32'(q_b.size()), 32'd32);
    for (int i = 0; i < q_b.size(); i++) checkOutput("sweep_value", 32'(q_b[i]), 32'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("[TB] FAIL timeout: stimulus did not complete by cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
